// File: rtl/edge_detect_multi_pkg.sv
// ============================================================================
// Module      : edge_pkg
// Description : Shared constants and helpers for the multi-channel edge
//               detector: per-channel mode encodings and a ceil(log2) helper
//               used to size the debounce counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_pkg;

    // Per-channel event selection, two bits per channel on i_Mode
    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect_multi_if.sv
// ============================================================================
// Module      : edge_detect_multi_if
// Description : Bundles the per-channel input and status buses of the
//               edge detector. The slave modport is the detector's view, the
//               master modport is the view of whatever drives and polls it.
//   i_Sig    : raw asynchronous levels, one bit per channel
//   i_Mode   : two mode bits per channel
//   i_Clr    : per-channel clear of sticky flag and counter
//   o_Level  : debounced levels
//   o_Rise   : one-cycle rising pulses
//   o_Fall   : one-cycle falling pulses
//   o_Edge   : mode-filtered event pulses
//   o_Sticky : latched event flags
//   o_Cnt    : CNT_W-bit saturating event counters, channel n at [n*CNT_W +: CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface edge_detect_multi_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic [CH-1:0]       i_Sig;
    logic [2*CH-1:0]     i_Mode;
    logic [CH-1:0]       i_Clr;
    logic [CH-1:0]       o_Level;
    logic [CH-1:0]       o_Rise;
    logic [CH-1:0]       o_Fall;
    logic [CH-1:0]       o_Edge;
    logic [CH-1:0]       o_Sticky;
    logic [CH*CNT_W-1:0] o_Cnt;

    modport master (
        output i_Sig, i_Mode, i_Clr,
        input  o_Level, o_Rise, o_Fall, o_Edge, o_Sticky, o_Cnt
    );

    modport slave (
        input  i_Sig, i_Mode, i_Clr,
        output o_Level, o_Rise, o_Fall, o_Edge, o_Sticky, o_Cnt
    );
endinterface

`default_nettype wire

// File: rtl/edge_detect_multi_chan.sv
// ============================================================================
// Module      : edge_chan
// Description : One edge-detector channel: synchroniser, debounce, rise/fall
//               pulse generation, mode-filtered event, sticky flag and
//               saturating event counter.
//   i_Clk    : clock, rising edge
//   i_Rstb   : asynchronous active-low reset
//   i_Sig    : raw asynchronous level
//   i_Mode   : 00 off, 01 rising, 10 falling, 11 both
//   i_Clr    : synchronous clear of sticky flag and counter
//   o_Level  : debounced level
//   o_Rise   : one-cycle pulse on debounced 0->1
//   o_Fall   : one-cycle pulse on debounced 1->0
//   o_Edge   : mode-filtered event pulse, aligned with o_Rise/o_Fall
//   o_Sticky : latched event flag
//   o_Cnt    : saturating event counter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC   = 2,
    parameter int DB_CNT = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic             i_Clk,
    input  wire logic             i_Rstb,
    input  wire logic             i_Sig,
    input  wire logic [1:0]       i_Mode,
    input  wire logic             i_Clr,
    output logic                  o_Level,
    output logic                  o_Rise,
    output logic                  o_Fall,
    output logic                  o_Edge,
    output logic                  o_Sticky,
    output logic [CNT_W-1:0]      o_Cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [SYNC-1:0]  r_sync;
    logic             w_s;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;
    logic             r_fall;
    logic             r_edge;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_fall;
    logic             w_rise_en;
    logic             w_fall_en;

    // Plain shift-register synchroniser; nothing combinational ahead of it
    always_ff @(posedge i_Clk or negedge i_Rstb) begin
        if (!i_Rstb) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_Sig};
        end
    end

    assign w_s = r_sync[SYNC-1];

    generate
        if (DB_CNT == 0) begin : g_no_db
            always_ff @(posedge i_Clk or negedge i_Rstb) begin
                if (!i_Rstb) begin
                    r_level <= 1'b0;
                end else begin
                    r_level <= w_s;
                end
            end
        end else begin : g_db
            localparam int             c_DB_W    = clog2(DB_CNT + 1);
            localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CNT - 1);

            logic              r_s_q;
            logic [c_DB_W-1:0] r_db_cnt;

            // r_s_q is the same single sampling stage the no-debounce build
            // uses for r_level, so both builds keep latency SYNC+DB_CNT+2.
            // The level flips only after DB_CNT consecutive samples that
            // disagree with it; any agreeing sample restarts the count.
            always_ff @(posedge i_Clk or negedge i_Rstb) begin
                if (!i_Rstb) begin
                    r_s_q    <= 1'b0;
                    r_db_cnt <= '0;
                    r_level  <= 1'b0;
                end else begin
                    r_s_q <= w_s;
                    if (r_s_q == r_level) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_level  <= r_s_q;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign w_rise    = r_level & ~r_level_d;
    assign w_fall    = ~r_level & r_level_d;
    assign w_rise_en = (i_Mode == EDGE_RISE) || (i_Mode == EDGE_BOTH);
    assign w_fall_en = (i_Mode == EDGE_FALL) || (i_Mode == EDGE_BOTH);

    always_ff @(posedge i_Clk or negedge i_Rstb) begin
        if (!i_Rstb) begin
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_edge    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= w_rise;
            r_fall    <= w_fall;
            r_edge    <= (w_rise_en & w_rise) | (w_fall_en & w_fall);
        end
    end

    // A clear arriving together with an event still records that event
    always_ff @(posedge i_Clk or negedge i_Rstb) begin
        if (!i_Rstb) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (r_edge) begin
                r_sticky <= 1'b1;
            end else if (i_Clr) begin
                r_sticky <= 1'b0;
            end

            if (i_Clr) begin
                r_cnt <= r_edge ? CNT_W'(1) : '0;
            end else if (r_edge && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_Level  = r_level;
    assign o_Rise   = r_rise;
    assign o_Fall   = r_fall;
    assign o_Edge   = r_edge;
    assign o_Sticky = r_sticky;
    assign o_Cnt    = r_cnt;

endmodule

`default_nettype wire

// File: rtl/edge_detect_multi.sv
// ============================================================================
// Module      : edge_detect_multi
// Description : Multi-channel edge detector. CH independent edge_chan
//               instances share only clock and reset; the interface buses
//               are sliced per channel.
//   i_Clk  : clock, rising edge
//   i_Rstb : asynchronous active-low reset (deassertion synchronised outside)
//   bus    : edge_detect_multi_if slave view (inputs, levels, pulses,
//            sticky flags, counters)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect_multi
    import edge_pkg::*;
#(
    parameter int CH     = 4,
    parameter int SYNC   = 2,
    parameter int DB_CNT = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic          i_Clk,
    input  wire logic          i_Rstb,
    edge_detect_multi_if.slave bus
);

    logic [CH-1:0]       w_level;
    logic [CH-1:0]       w_rise;
    logic [CH-1:0]       w_fall;
    logic [CH-1:0]       w_edge;
    logic [CH-1:0]       w_sticky;
    logic [CH*CNT_W-1:0] w_cnt;

    generate
        for (genvar n = 0; n < CH; n++) begin : g_chan
            edge_chan #(
                .SYNC   (SYNC),
                .DB_CNT (DB_CNT),
                .CNT_W  (CNT_W)
            ) u_chan (
                .i_Clk    (i_Clk),
                .i_Rstb   (i_Rstb),
                .i_Sig    (bus.i_Sig[n]),
                .i_Mode   (bus.i_Mode[2*n +: 2]),
                .i_Clr    (bus.i_Clr[n]),
                .o_Level  (w_level[n]),
                .o_Rise   (w_rise[n]),
                .o_Fall   (w_fall[n]),
                .o_Edge   (w_edge[n]),
                .o_Sticky (w_sticky[n]),
                .o_Cnt    (w_cnt[n*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.o_Level  = w_level;
    assign bus.o_Rise   = w_rise;
    assign bus.o_Fall   = w_fall;
    assign bus.o_Edge   = w_edge;
    assign bus.o_Sticky = w_sticky;
    assign bus.o_Cnt    = w_cnt;

endmodule

`default_nettype wire
